alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that time-shares the single 32-bit ALU (funct 000 add, 001 sub, 010 and, 011 or, 100 set-less-than) between two requesters, e.g. the execute stage and the branch/address unit.
- Accepts one operation at a time over a valid/ready handshake, drives the ALU operand and funct inputs from registered copies, waits a fixed settle time, then captures result and zero flag and returns them with the requester ID.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width.
- ALU_LAT, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_funct  in  3  requester 0 ALU function.
- req0_a  in  WIDTH  requester 0 operand 1.
- req0_b  in  WIDTH  requester 0 operand 2.
- req1_valid, req1_ready, req1_funct, req1_a, req1_b: same as above, for requester 1.
- alu_funct  out  3  to ALU funct2.
- alu_in1  out  WIDTH  to ALU in1.
- alu_in2  out  WIDTH  to ALU in2.
- alu_result  in  WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the op (0/1).
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  funct was illegal (101..111).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter=0; last_grant=1, so req0 wins the first tie.
  - All outputs 0: req*_ready, alu_funct, alu_in1, alu_in2, rsp_*.
  - Reset mid-operation discards the in-flight op; no response is produced.
- State IDLE:
  - grant is combinational: if only one valid, grant it; if both valid, grant the requester != last_grant (round robin).
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N; never both high in the same cycle.
  - On handshake: latch funct/a/b into alu_funct/alu_in1/alu_in2, record id, last_grant=id, counter=ALU_LAT-1.
  - Next state is EXEC, or ERR if funct>3'b100.
- State EXEC:
  - ALU inputs held constant. If counter!=0, decrement.
  - If counter==0: capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_err=0, rsp_id=id; go to RESP.
  - Minimum issue-to-capture latency is ALU_LAT cycles after the accept edge.
- State ERR (one cycle): rsp_result=0, rsp_zero=0, rsp_err=1, rsp_id=id; ALU not consulted; go to RESP.
- State RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid=0 next cycle, go to IDLE; rsp_* data retain last values.
  - No new request is accepted in EXEC/ERR/RESP.
  - Back-to-back throughput: one op per ALU_LAT+2 cycles with rsp_ready tied high.
- Requests that drop valid before ready are simply not accepted; no state is kept.
- alu_* outputs keep their last values in IDLE, so ALU outputs stay stable (no glitching).
- Width rules: no arithmetic inside the block other than the 4-bit counter; operand and result bits pass through unmodified.

Optional Feature:
- Macro ALU_SHARE_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority. req0 always wins when both are valid; last_grant is unused. req1 can starve, by design, for latency-critical requester 0.
- Undefined (default): round robin as specified above.

Test Plan:
- Single op: ALU_LAT=1, req0 add a=5, b=7 -> req0_ready one cycle; rsp_valid 2 cycles after accept; rsp_result=12, rsp_zero=0, rsp_id=0, rsp_err=0.
- Zero flag: req1 sub a=9, b=9 -> rsp_result=0, rsp_zero=1, rsp_id=1. Then slt a=3, b=4 -> rsp_result=1. Then slt a=4, b=3 -> rsp_result=0.
- Fairness: both valid continuously, four ops each -> grants alternate 0,1,0,1,...; the first grant goes to req0.
  - With ALU_SHARE_FIXED_PRIO_EN defined: all four req0 ops complete before any req1 op.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and both req*_ready stay 0. rsp_ready=1 -> IDLE next cycle; a pending request is accepted the cycle after.
- Illegal funct: req0 funct=3'b110 -> rsp_err=1, rsp_result=0, rsp_zero=0; alu_in1/alu_in2 show the operands but the ALU output is ignored. The next legal op responds normally with rsp_err=0.
- Reset mid-op: ALU_LAT=4, assert rst_n=0 two cycles after accept -> all outputs 0 immediately. After release, no stale response appears, and a new req1 or op is accepted and completes correctly.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters: accept one op, hold the ALU inputs for ALU_LAT cycles, return the captured result.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (req0 always wins); the default build is round robin.
module alu_share_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_funct,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_funct,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [2:0]       alu_funct,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
    localparam logic [2:0] FUNCT_MAX = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ERR,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       counter;
    logic             id;
    logic             grant;
    logic             accept;
    logic [2:0]       sel_funct;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    always_comb begin
        grant = !req0_valid && req1_valid;
    end
`else
    logic last_grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end
`endif

    // Ready is gated by rst_n so both ready outputs read 0 while reset is held.
    always_comb begin
        req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
        req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        sel_funct  = grant ? req1_funct : req0_funct;
        sel_a      = grant ? req1_a : req0_a;
        sel_b      = grant ? req1_b : req0_b;
    end

    always_comb begin
        state_nxt = state;
        rsp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (sel_funct > FUNCT_MAX) ? ERR : EXEC;
                end
            end
            EXEC: begin
                if (counter == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            ERR: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifndef ALU_SHARE_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`endif

    // ALU inputs are only loaded on accept, so they stay stable outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            id         <= 1'b0;
            alu_funct  <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_funct <= sel_funct;
                        alu_in1   <= sel_a;
                        alu_in2   <= sel_b;
                        id        <= grant;
                        counter   <= LAT_M1;
                    end
                end
                EXEC: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                        rsp_id     <= id;
                    end
                end
                ERR: begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                    rsp_err    <= 1'b1;
                    rsp_id     <= id;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table plus hand-written fairness, backpressure and reset sequences.
module tb_alu_share_ctrl;

    localparam int W    = 32;
    localparam int LAT1 = 1;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ALU_LAT=1 instance
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_funct, req1_funct, alu_funct;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_in1, alu_in2, alu_result, rsp_result;
    logic         alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;

    // ALU_LAT=4 instance
    logic         q_rst_n;
    logic         q_req0_valid, q_req0_ready, q_req1_valid, q_req1_ready;
    logic [2:0]   q_req0_funct, q_req1_funct, q_alu_funct;
    logic [W-1:0] q_req0_a, q_req0_b, q_req1_a, q_req1_b, q_alu_in1, q_alu_in2, q_alu_result, q_rsp_result;
    logic         q_alu_zero, q_rsp_valid, q_rsp_ready, q_rsp_id, q_rsp_zero, q_rsp_err;

    // Stand-in ALU; illegal functs return garbage with zero=1 so leaking it is visible.
    function automatic logic [W:0] alu_fn(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (f)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'hDEAD_BEEF;
        endcase
        return {(f > 3'b100) ? 1'b1 : (r == '0), r};
    endfunction

    assign {alu_zero, alu_result}     = alu_fn(alu_funct, alu_in1, alu_in2);
    assign {q_alu_zero, q_alu_result} = alu_fn(q_alu_funct, q_alu_in1, q_alu_in2);

    alu_share_ctrl #(.WIDTH(W), .ALU_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
        .alu_funct(alu_funct), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    alu_share_ctrl #(.WIDTH(W), .ALU_LAT(LAT4)) dut4 (
        .clk(clk), .rst_n(q_rst_n),
        .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_funct(q_req0_funct), .req0_a(q_req0_a), .req0_b(q_req0_b),
        .req1_valid(q_req1_valid), .req1_ready(q_req1_ready), .req1_funct(q_req1_funct), .req1_a(q_req1_a), .req1_b(q_req1_b),
        .alu_funct(q_alu_funct), .alu_in1(q_alu_in1), .alu_in2(q_alu_in2), .alu_result(q_alu_result), .alu_zero(q_alu_zero),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id), .rsp_result(q_rsp_result),
        .rsp_zero(q_rsp_zero), .rsp_err(q_rsp_err)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic         id;
        logic [2:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } vec_t;

    vec_t vecs[10];

    task automatic run_op(input vec_t v);
        bit got;
        int n;
        @(posedge clk); #1;
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_funct = v.funct; req0_a = v.a; req0_b = v.b;
        end else begin
            req1_valid = 1'b1; req1_funct = v.funct; req1_a = v.a; req1_b = v.b;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) got = 1'b1;
        end
        check("op_ready_seen", 32'(got), 32'd1);
        check("op_ready_sel", 32'(v.id ? req1_ready : req0_ready), 32'd1);
        check("op_ready_other", 32'(v.id ? req0_ready : req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("op_alu_funct", 32'(alu_funct), 32'(v.funct));
                check("op_alu_in1", alu_in1, v.a);
                check("op_alu_in2", alu_in2, v.b);
            end
            if (rsp_valid) got = 1'b1;
            else n++;
        end
        check("op_rsp_seen", 32'(got), 32'd1);
        check("op_latency", 32'(n), v.err ? 32'd1 : 32'(LAT1));
        check("op_rsp_result", rsp_result, v.res);
        check("op_rsp_zero", 32'(rsp_zero), 32'(v.zero));
        check("op_rsp_err", 32'(rsp_err), 32'(v.err));
        check("op_rsp_id", 32'(rsp_id), 32'(v.id));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("op_rsp_drop", 32'(rsp_valid), 32'd0);
        check("op_rsp_retain", rsp_result, v.res);
    endtask

    initial begin : watchdog
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit got;
        int g, exp_g, cnt0, cnt1, last_cyc, n;
        logic [W-1:0] snap;

        vecs[0] = '{1'b0, 3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'b001, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[2] = '{1'b1, 3'b100, 32'd3,          32'd4,          32'd1,          1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'b100, 32'd4,          32'd3,          32'd0,          1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'b110, 32'h0000_1234,  32'h0000_5678,  32'd0,          1'b0, 1'b1};
        vecs[5] = '{1'b0, 3'b010, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 3'b011, 32'h8000_0000,  32'h0000_0001,  32'h8000_0001,  1'b0, 1'b0};
        vecs[7] = '{1'b0, 3'b100, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[8] = '{1'b1, 3'b111, 32'hAAAA_5555,  32'h1111_2222,  32'd0,          1'b0, 1'b1};
        vecs[9] = '{1'b1, 3'b001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0};

        rst_n = 1'b0; q_rst_n = 1'b0;
        req0_valid = 1'b1; req0_funct = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b0; req1_funct = 3'b000; req1_a = '0;    req1_b = '0;
        rsp_ready = 1'b0;
        q_req0_valid = 1'b0; q_req0_funct = '0; q_req0_a = '0; q_req0_b = '0;
        q_req1_valid = 1'b0; q_req1_funct = '0; q_req1_a = '0; q_req1_b = '0;
        q_rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_alu_funct", 32'(alu_funct), 32'd0);
        check("rst_rsp", {28'd0, rsp_valid, rsp_id, rsp_zero, rsp_err}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        q_rst_n = 1'b1;

        // Fairness: both requesters continuously valid for four ops each.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_funct = 3'b000; req0_a = 32'd1;    req0_b = 32'd2;
        req1_valid = 1'b1; req1_funct = 3'b011; req1_a = 32'hF0;   req1_b = 32'h0F;
        cnt0 = 0; cnt1 = 0; last_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) got = 1'b1;
            end
            check("fair_ready_seen", 32'(got), 32'd1);
            check("fair_onehot", 32'(req0_ready && req1_ready), 32'd0);
            g = int'(req1_ready);
`ifdef ALU_SHARE_FIXED_PRIO_EN
            exp_g = (k >= 4) ? 1 : 0;
`else
            exp_g = k % 2;
`endif
            check("fair_grant", 32'(g), 32'(exp_g));
            if (k > 0) check("fair_throughput", 32'(cyc - last_cyc), 32'(LAT1 + 2));
            last_cyc = cyc;
            @(posedge clk); #1;
            if (g == 0) begin
                cnt0++;
                if (cnt0 == 4) req0_valid = 1'b0;
            end else begin
                cnt1++;
                if (cnt1 == 4) req1_valid = 1'b0;
            end
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (rsp_valid) got = 1'b1;
            end
            check("fair_rsp_id", 32'(rsp_id), 32'(g));
            check("fair_rsp_result", rsp_result, (g == 1) ? 32'hFF : 32'd3);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

        for (int v = 0; v < 10; v++) run_op(vecs[v]);

        // Backpressure: response held 5 cycles while req1 waits.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_funct = 3'b000; req0_a = 32'h100; req0_b = 32'h23;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1'b1;
        end
        check("bp_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_funct = 3'b001; req1_a = 32'd6; req1_b = 32'd3;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check("bp_rsp_seen", 32'(got), 32'd1);
        snap = rsp_result;
        for (int j = 0; j < 5; j++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_result", rsp_result, 32'h123);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            check("bp_no_ready", 32'(req0_ready || req1_ready), 32'd0);
            @(negedge clk);
        end
        check("bp_stable", rsp_result, snap);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("bp_pending_ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check("bp2_result", rsp_result, 32'd3);
        check("bp2_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset two cycles into a four-cycle op on the ALU_LAT=4 instance.
        q_req0_valid = 1'b1; q_req0_funct = 3'b000; q_req0_a = 32'd20; q_req0_b = 32'd22;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (q_req0_ready) got = 1'b1;
        end
        check("r4_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        q_req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("r4_pre_alu_in1", q_alu_in1, 32'd20);
        q_req1_valid = 1'b1;
        q_rst_n = 1'b0;
        #1;
        check("r4_rst_alu_in1", q_alu_in1, 32'd0);
        check("r4_rst_alu_in2", q_alu_in2, 32'd0);
        check("r4_rst_ready", {30'd0, q_req0_ready, q_req1_ready}, 32'd0);
        check("r4_rst_rsp", {28'd0, q_rsp_valid, q_rsp_id, q_rsp_zero, q_rsp_err}, 32'd0);
        @(negedge clk);
        q_req1_valid = 1'b0;
        q_rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (q_rsp_valid) got = 1'b1;
        end
        check("r4_no_stale_rsp", 32'(got), 32'd0);
        @(posedge clk); #1;
        q_req1_valid = 1'b1; q_req1_funct = 3'b001; q_req1_a = 32'd50; q_req1_b = 32'd8;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (q_req1_ready) got = 1'b1;
        end
        check("r4_new_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        q_req1_valid = 1'b0;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (q_rsp_valid) got = 1'b1;
            else n++;
        end
        check("r4_latency", 32'(n), 32'(LAT4));
        check("r4_result", q_rsp_result, 32'd42);
        check("r4_id", 32'(q_rsp_id), 32'd1);
        check("r4_err", 32'(q_rsp_err), 32'd0);
        q_rsp_ready = 1'b1;
        @(posedge clk); #1;
        q_rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
